round_timer_ctrl: RTL
=====================

Name: round_timer_ctrl

Overview:
- Sequences the per-round countdown for the binary number game: loads the round time chosen by the game logic, counts it down in whole seconds and reports expiry.
- Sits between the game-state block (which supplies the start strobe and time value) and the display/compare path (which consumes remaining seconds and the timeout flag).
- Replaces ad-hoc time handling with one clocked, deterministic timer that has an abort path for early guesses.

Parameters:
- TICK_DIV, 50000000, clock cycles per one-second tick; must be >= 2; internal prescaler is clog2(TICK_DIV) bits.
- MIN_TIME, 3, lower clamp applied to the loaded round time, in seconds.
- WARN_TIME, 5, warn asserts while remaining <= WARN_TIME during RUN.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; synchronous and active-high.
- start  input  1  single-cycle strobe: load load_val and begin the countdown.
- load_val  input  5  requested round time in seconds (0..31).
- abort  input  1  single-cycle strobe: guess submitted, stop the countdown and freeze remaining.
- remaining  output  5  seconds left, for the display.
- running  output  1  high while in RUN.
- warn  output  1  low-time indicator.
- end_p  output  1  one-cycle pulse on expiry.
- timeout  output  1  sticky expiry flag; cleared by start or rst.

Behaviour:
- States: IDLE, RUN, STOPPED, EXPIRED. All transitions are on posedge clk.
- Reset (rst=1 at a clock edge):
  - state=IDLE, remaining=0, running=0, warn=0, end_p=0, timeout=0, prescaler=0.
  - Reset overrides all other inputs in the same cycle, including mid-countdown.
- Load value:
  - eff = (load_val < MIN_TIME) ? MIN_TIME : load_val.
  - Comparison is unsigned, 5-bit. No upper clamp; 31 is legal.
- start in any state:
  - Next cycle: state=RUN, remaining=eff, prescaler=0, timeout=0, end_p=0.
  - A start during RUN restarts the countdown.
- RUN:
  - prescaler increments each cycle. When it reaches TICK_DIV-1 it wraps to 0 and a tick occurs.
  - On a tick with remaining>1: remaining decrements by 1.
  - On a tick with remaining==1: remaining=0, state=EXPIRED, end_p=1 for exactly that one following cycle, timeout=1.
  - First decrement lands exactly TICK_DIV cycles after the cycle in which start was sampled. Expiry lands at eff*TICK_DIV cycles.
- abort:
  - In RUN: state=STOPPED next cycle, remaining frozen, prescaler held, timeout stays 0.
  - In IDLE, STOPPED or EXPIRED: ignored.
- Simultaneous events:
  - start and abort in the same cycle: start wins.
  - abort on the same cycle as the final tick: abort wins. The player guessed in time, so no end_p and timeout stays 0.
  - start on the same cycle as the final tick: start wins, so no end_p.
- STOPPED and EXPIRED hold until start or rst. remaining stays at its frozen value in STOPPED and at 0 in EXPIRED.
- Outputs:
  - running = (state==RUN).
  - warn = running && remaining <= WARN_TIME; warn is 0 outside RUN.
  - All outputs are registered; no combinational path from inputs to outputs.
- remaining never underflows below 0 and never wraps.

Test Plan:
- Sim with TICK_DIV=4.
- Reset: assert rst for 2 cycles mid-RUN (remaining=7) -> next cycle remaining=0, running=0, timeout=0, end_p=0, state IDLE.
- Normal expiry: start with load_val=5 -> remaining=5 the cycle after start, then 4 at +4 cycles; end_p pulses once at +20 cycles with remaining=0; timeout stays 1; warn=1 throughout RUN (5<=WARN_TIME).
- Clamp: load_val=0 and load_val=2 -> remaining loads 3. load_val=31 -> loads 31; warn=0 until remaining=5.
- Abort: start with load_val=10, pulse abort at cycle 9 -> remaining frozen at 8, running=0, no end_p over 100 further cycles, timeout=0.
- Race cases:
  - abort coincident with the final tick (remaining=1) -> no end_p, timeout=0, state STOPPED.
  - start and abort in the same cycle -> RUN with remaining=eff.
- Restart: start during RUN at remaining=4 with load_val=9 -> remaining=9, prescaler restarted (next decrement exactly 4 cycles later). start from EXPIRED clears timeout in the same next cycle.

Source files
------------

// File: rtl/round_timer_ctrl_if.sv
// Bundles the signals exchanged between the game-state block and the round
// timer. The game side drives the round controls and consumes the countdown
// status. The timer side does the reverse.
interface round_timer_ctrl_if;

  // Round controls driven by the game-state block.
  logic       start;      // single-cycle strobe: load and begin countdown
  logic [4:0] load_val;   // requested round time in seconds
  logic       abort;      // single-cycle strobe: guess submitted

  // Countdown status returned by the timer.
  logic [4:0] remaining;  // seconds left, for the display
  logic       running;    // countdown in progress
  logic       warn;       // low-time indicator
  logic       end_p;      // one-cycle expiry pulse
  logic       timeout;    // sticky expiry flag

  // Game-state side: issues commands and watches the countdown.
  modport master (
    output start, load_val, abort,
    input  remaining, running, warn, end_p, timeout
  );

  // Timer side: accepts commands and reports the countdown.
  modport slave (
    input  start, load_val, abort,
    output remaining, running, warn, end_p, timeout
  );

endinterface : round_timer_ctrl_if

// File: rtl/round_timer_ctrl.sv
// Per-round countdown timer for the binary number game.
// Loads a clamped round time on start, counts it down once per TICK_DIV
// clocks and flags expiry. An abort (early guess) freezes the count.
// Every output comes straight from a flop, so no input reaches an output
// in the same cycle.
module round_timer_ctrl #(
  parameter int TICK_DIV  = 50000000,  // clock cycles per one-second tick, >= 2
  parameter int MIN_TIME  = 3,         // lower clamp on the loaded round time
  parameter int WARN_TIME = 5          // warn while remaining <= this in RUN
) (
  input  logic         clk,
  input  logic         rst,
  round_timer_ctrl_if.slave bus
);

  // Prescaler width and the terminal count that produces a tick.
  localparam int                PS_W     = $clog2(TICK_DIV);
  localparam logic [PS_W-1:0]   PS_LAST  = PS_W'(TICK_DIV - 1);
  localparam logic [PS_W-1:0]   PS_ONE   = PS_W'(1);

  // Second-valued thresholds, sized to match the 5-bit seconds counter.
  localparam logic [4:0]        MIN_SEC  = 5'(MIN_TIME);
  localparam logic [4:0]        WARN_SEC = 5'(WARN_TIME);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    STOPPED = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  // Registered state and outputs.
  state_t          state;
  logic [4:0]      remaining_q;
  logic [PS_W-1:0] prescaler;
  logic            running_q;
  logic            warn_q;
  logic            end_p_q;
  logic            timeout_q;

  // Next-state values.
  state_t          state_nxt;
  logic [4:0]      remaining_nxt;
  logic [PS_W-1:0] prescaler_nxt;
  logic            end_p_nxt;
  logic            timeout_nxt;

  // Decoded helpers.
  logic [4:0]      eff_time;
  logic            tick;

  // Clamp short requests up to the minimum round length. There is no upper
  // clamp because the full 5-bit range is a legal round time.
  assign eff_time = (bus.load_val < MIN_SEC) ? MIN_SEC : bus.load_val;

  // A one-second tick happens on the cycle the prescaler sits at its last count.
  assign tick = (prescaler == PS_LAST);

  // Next-state and datapath decode. start takes priority over everything,
  // and abort takes priority over the tick inside RUN.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_nxt     = state;
    remaining_nxt = remaining_q;
    prescaler_nxt = prescaler;
    end_p_nxt     = 1'b0;
    timeout_nxt   = timeout_q;

    if (bus.start) begin
      // Load from any state. This also restarts a countdown already running
      // and clears a previous expiry.
      state_nxt     = RUN;
      remaining_nxt = eff_time;
      prescaler_nxt = '0;
      timeout_nxt   = 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (bus.abort) begin
            // Guess arrived in time: freeze remaining and the prescaler.
            state_nxt = STOPPED;
          end else if (tick) begin
            prescaler_nxt = '0;
            if (remaining_q > 5'd1) begin
              remaining_nxt = remaining_q - 5'd1;
            end else begin
              // Final second elapsed. Land on zero without wrapping.
              remaining_nxt = 5'd0;
              state_nxt     = EXPIRED;
              end_p_nxt     = 1'b1;
              timeout_nxt   = 1'b1;
            end
          end else begin
            prescaler_nxt = prescaler + PS_ONE;
          end
        end
        // IDLE, STOPPED and EXPIRED hold until start or rst. abort is ignored here.
        IDLE, STOPPED, EXPIRED: begin
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // State and output registers. Synchronous reset overrides every input.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only. All flops
    // then update from the same pre-edge values, with no ordering races.
    if (rst) begin
      state       <= IDLE;
      remaining_q <= 5'd0;
      prescaler   <= '0;
      running_q   <= 1'b0;
      warn_q      <= 1'b0;
      end_p_q     <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state       <= state_nxt;
      remaining_q <= remaining_nxt;
      prescaler   <= prescaler_nxt;
      // running and warn are computed from next-state values, so they line
      // up with the state and remaining they describe.
      running_q   <= (state_nxt == RUN);
      warn_q      <= (state_nxt == RUN) && (remaining_nxt <= WARN_SEC);
      end_p_q     <= end_p_nxt;
      timeout_q   <= timeout_nxt;
    end
  end

  // Drive the interface from the output registers.
  assign bus.remaining = remaining_q;
  assign bus.running   = running_q;
  assign bus.warn      = warn_q;
  assign bus.end_p     = end_p_q;
  assign bus.timeout   = timeout_q;

endmodule : round_timer_ctrl
